dram_arbiter: RTL

Two-master AHB-Lite arbiter and sequencer for one byte-laned data RAM bank (four 8-bit RAMs sharing one 12-bit word address). Master 0 is the core data port; master 1 is the SPI loader. The block arbitrates address phases round-robin and honours master lock. It decodes size and offset into byte write enables, sequences the synchronous RAM, and returns per-master hready, hresp and hrdata.

---
 rtl/ahb_pkg.sv | 43 ++++
 rtl/ahb_lane_decode.sv | 36 +++
 rtl/dram_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_pkg
// Description : Shared AHB-Lite encodings and arbiter state type for the
//               data RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_pkg;

  // HTRANS encodings
  localparam logic [1:0] c_HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] c_HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] c_HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] c_HTRANS_SEQ    = 2'd3;

  // HSIZE encodings supported by the RAM bank
  localparam logic [2:0] c_HSIZE_BYTE = 3'd0;
  localparam logic [2:0] c_HSIZE_HALF = 3'd1;
  localparam logic [2:0] c_HSIZE_WORD = 3'd2;

  // Data-phase sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WDATA = 3'd1,
    ST_RD1   = 3'd2,
    ST_RDATA = 3'd3,
    ST_ERR1  = 3'd4,
    ST_ERR2  = 3'd5
  } arb_state_t;

  // A transfer is a real request only for NONSEQ or SEQ
  function automatic logic is_req(input logic [1:0] htrans);
    logic r;
    case (htrans)
      c_HTRANS_NONSEQ, c_HTRANS_SEQ: r = 1'b1;
      c_HTRANS_IDLE, c_HTRANS_BUSY:  r = 1'b0;
      default:                       r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_lane_decode.sv
`default_nettype none
// ============================================================================
// Module      : ahb_lane_decode
// Description : Turns hsize and the low address bits into byte-lane write
//               enables, flagging unsupported sizes and misalignment.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_lane_decode
  import ahb_pkg::*;
(
  input  logic [2:0] i_hsize,
  input  logic [1:0] i_addr_lo,
  output logic [3:0] o_wben,
  output logic       o_err
);

  // Lane mask and alignment check for the granted address phase
  always_comb begin
    o_wben = 4'b0000;
    o_err  = 1'b0;
    case (i_hsize)
      c_HSIZE_BYTE: o_wben = 4'b0001 << i_addr_lo;
      c_HSIZE_HALF: begin
        o_wben = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_err  = i_addr_lo[0];
      end
      c_HSIZE_WORD: begin
        o_wben = 4'b1111;
        o_err  = |i_addr_lo;
      end
      default: o_err = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dram_arbiter
// Description : Two-master AHB-Lite round-robin arbiter with lock support,
//               sequencing one byte-laned synchronous data RAM bank.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_arbiter
  import ahb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_haddr,
  input  logic        m0_hwrite,
  input  logic [2:0]  m0_hsize,
  input  logic [1:0]  m0_htrans,
  input  logic        m0_hmastlock,
  input  logic [31:0] m0_hwdata,
  output logic [31:0] m0_hrdata,
  output logic        m0_hready,
  output logic        m0_hresp,
  input  logic [31:0] m1_haddr,
  input  logic        m1_hwrite,
  input  logic [2:0]  m1_hsize,
  input  logic [1:0]  m1_htrans,
  input  logic        m1_hmastlock,
  input  logic [31:0] m1_hwdata,
  output logic [31:0] m1_hrdata,
  output logic        m1_hready,
  output logic        m1_hresp,
  output logic [11:0] ram_addr,
  output logic        ram_rwn,
  output logic [3:0]  ram_wben,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  arb_state_t  r_state;
  logic        r_owner;     // master owning the current data phase
  logic        r_last_gnt;  // master granted most recently (also lock owner)
  logic        r_lock;      // owner's accepted transfer asked for a lock
  logic [11:0] r_addr;
  logic [3:0]  r_wben;

  logic        w_req0, w_req1;
  logic        w_accept_win;
  logic        w_own_req, w_own_lock;
  logic        w_gnt_valid, w_gnt_id;
  logic [13:0] w_g_addr;
  logic [2:0]  w_g_size;
  logic        w_g_write, w_g_lock;
  logic [3:0]  w_dec_wben;
  logic        w_dec_err;
  logic        w_wr;
  logic        w_own0, w_own1;
  logic        w_dp_ready, w_dp_resp;
  logic [31:0] w_dp_rdata;
  logic        w_unused;

  assign w_unused = ^{m0_haddr[31:14], m1_haddr[31:14]};

  assign w_req0 = is_req(m0_htrans);
  assign w_req1 = is_req(m1_htrans);

  // Address phases are taken only when no data phase is stalling the bus
  assign w_accept_win = !reset && (r_state == ST_IDLE  || r_state == ST_WDATA ||
                                   r_state == ST_RDATA || r_state == ST_ERR2);

  assign w_own_req  = r_last_gnt ? w_req1 : w_req0;
  assign w_own_lock = r_last_gnt ? m1_hmastlock : m0_hmastlock;

  // Grant: a held lock pins the owner, otherwise round-robin on ties
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_id    = 1'b0;
    if (w_accept_win) begin
      if (r_lock && w_own_req && w_own_lock) begin
        w_gnt_valid = 1'b1;
        w_gnt_id    = r_last_gnt;
      end else if (w_req0 && w_req1) begin
        w_gnt_valid = 1'b1;
        w_gnt_id    = ~r_last_gnt;
      end else if (w_req0) begin
        w_gnt_valid = 1'b1;
        w_gnt_id    = 1'b0;
      end else if (w_req1) begin
        w_gnt_valid = 1'b1;
        w_gnt_id    = 1'b1;
      end
    end
  end

  assign w_g_addr  = w_gnt_id ? m1_haddr[13:0] : m0_haddr[13:0];
  assign w_g_size  = w_gnt_id ? m1_hsize       : m0_hsize;
  assign w_g_write = w_gnt_id ? m1_hwrite      : m0_hwrite;
  assign w_g_lock  = w_gnt_id ? m1_hmastlock   : m0_hmastlock;

  ahb_lane_decode u_lane_decode (
    .i_hsize   (w_g_size),
    .i_addr_lo (w_g_addr[1:0]),
    .o_wben    (w_dec_wben),
    .o_err     (w_dec_err)
  );

  // Sequencer: capture the granted transfer and step through its data phase
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_owner    <= 1'b0;
      r_last_gnt <= 1'b1;
      r_lock     <= 1'b0;
      r_addr     <= 12'd0;
      r_wben     <= 4'd0;
    end else if (w_gnt_valid) begin
      r_owner    <= w_gnt_id;
      r_last_gnt <= w_gnt_id;
      r_lock     <= w_g_lock;
      r_addr     <= w_g_addr[13:2];
      r_wben     <= w_dec_wben;
      if (w_dec_err)      r_state <= ST_ERR1;
      else if (w_g_write) r_state <= ST_WDATA;
      else                r_state <= ST_RD1;
    end else begin
      case (r_state)
        ST_RD1:  r_state <= ST_RDATA;
        ST_ERR1: r_state <= ST_ERR2;
        default: begin
          // Accept window with nobody granted: owner went idle, lock drops
          r_state <= ST_IDLE;
          r_lock  <= 1'b0;
        end
      endcase
    end
  end

  // RAM write strobes are suppressed in a reset cycle so nothing is corrupted
  assign w_wr      = (r_state == ST_WDATA) && !reset;
  assign ram_rwn   = ~w_wr;
  assign ram_wben  = w_wr ? r_wben : 4'd0;
  assign ram_wdata = w_wr ? (r_owner ? m1_hwdata : m0_hwdata) : 32'd0;
  assign ram_addr  = (r_state == ST_WDATA || r_state == ST_RD1) ? r_addr : 12'd0;

  assign w_own0     = (r_state != ST_IDLE) && !r_owner;
  assign w_own1     = (r_state != ST_IDLE) &&  r_owner;
  assign w_dp_ready = (r_state == ST_WDATA) || (r_state == ST_RDATA) || (r_state == ST_ERR2);
  assign w_dp_resp  = (r_state == ST_ERR1)  || (r_state == ST_ERR2);
  assign w_dp_rdata = (r_state == ST_RDATA) ? ram_rdata : 32'd0;

  // Owner sees its data-phase response; a non-owner stalls only while blocked
  assign m0_hready = w_own0 ? w_dp_ready : (!w_req0 || (w_gnt_valid && !w_gnt_id));
  assign m1_hready = w_own1 ? w_dp_ready : (!w_req1 || (w_gnt_valid &&  w_gnt_id));
  assign m0_hresp  = w_own0 && w_dp_resp;
  assign m1_hresp  = w_own1 && w_dp_resp;
  assign m0_hrdata = w_own0 ? w_dp_rdata : 32'd0;
  assign m1_hrdata = w_own1 ? w_dp_rdata : 32'd0;

endmodule
`default_nettype wire
